// File: rtl/mux_81_rr_arbiter_pkg.sv
// Shared types and pick helpers for the round-robin 8:1 mux arbiter.
package mux81_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] sel);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

    // First set request at or after ptr, wrapping 7->0; idx is 0 when nothing is found.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                      input logic [SEL_W-1:0] ptr);
        pick_t            p;
        logic [SEL_W-1:0] cand;
        p = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ptr + SEL_W'(i);
            if (!p.found && req[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mux_81_rr_arbiter_if.sv
// Requester/consumer bundle of the round-robin 8:1 mux arbiter.
interface mux_81_rr_arbiter_if #(
    parameter int WIDTH = 16
);
    import mux81_pkg::*;

    logic [N_REQ-1:0] req;
    logic [WIDTH-1:0] a, b, c, d, e, f, g, h;
    logic [WIDTH-1:0] y;
    logic             y_valid;
    logic             y_ready;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] ack;
    logic             s2, s1, s0;

    modport master (
        input  req, a, b, c, d, e, f, g, h, y_ready,
        output y, y_valid, grant, ack, s2, s1, s0
    );

    modport slave (
        output req, a, b, c, d, e, f, g, h, y_ready,
        input  y, y_valid, grant, ack, s2, s1, s0
    );

endinterface

// File: rtl/mux_81_rr_arbiter_mux.sv
// Gate-level 8:1 mux, WIDTH bits wide, select {s2,s1,s0}: 0 picks a ... 7 picks h.
module mux_81_16bit_gatelevel #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] h,
    input  logic             s2,
    input  logic             s1,
    input  logic             s0,
    output logic [WIDTH-1:0] y
);

    wire n2, n1, n0;
    wire [7:0] dec;

    not u_n2 (n2, s2);
    not u_n1 (n1, s1);
    not u_n0 (n0, s0);

    and u_d0 (dec[0], n2, n1, n0);
    and u_d1 (dec[1], n2, n1, s0);
    and u_d2 (dec[2], n2, s1, n0);
    and u_d3 (dec[3], n2, s1, s0);
    and u_d4 (dec[4], s2, n1, n0);
    and u_d5 (dec[5], s2, n1, s0);
    and u_d6 (dec[6], s2, s1, n0);
    and u_d7 (dec[7], s2, s1, s0);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        wire [7:0] t;
        and u_t0 (t[0], a[i], dec[0]);
        and u_t1 (t[1], b[i], dec[1]);
        and u_t2 (t[2], c[i], dec[2]);
        and u_t3 (t[3], d[i], dec[3]);
        and u_t4 (t[4], e[i], dec[4]);
        and u_t5 (t[5], f[i], dec[5]);
        and u_t6 (t[6], g[i], dec[6]);
        and u_t7 (t[7], h[i], dec[7]);
        or  u_o   (y[i], t[0], t[1], t[2], t[3], t[4], t[5], t[6], t[7]);
    end

endmodule

// File: rtl/mux_81_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 mux among 8 requesters, registered valid/ready output.
// Optional MUX81_ARB_BURST_EN lets an owner keep the grant for up to BURST_LEN words.
module mux_81_rr_arbiter
    import mux81_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int BURST_LEN = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_81_rr_arbiter_if.master bus
);

    // The burst counter is 3 bits wide.
    if (BURST_LEN < 1 || BURST_LEN > 7) begin : g_burst_len_check
        $error("BURST_LEN must be in 1..7");
    end

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] owner_q, owner_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] mux_out;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] pick_base;
    pick_t            pick;
    logic             hs;
    logic             load;
    logic             keep;
    logic             y_valid;

`ifdef MUX81_ARB_BURST_EN
    logic [2:0] cnt_q, cnt_d;

    assign keep = hs && bus.req[owner_q] && (cnt_q < 3'(BURST_LEN));

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = keep ? cnt_q + 3'd1 : 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign keep = 1'b0;
`endif

    assign y_valid = (state_q == HOLD);
    assign hs      = y_valid && bus.y_ready;

    // On a handshake the scan restarts just past the current owner.
    assign pick_base = hs ? owner_q + 3'd1 : ptr_q;
    assign pick      = rr_pick(bus.req, pick_base);

    always_comb begin
        sel       = pick.idx;
        load      = 1'b0;
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        grant_d   = grant_q;
        y_d       = y_q;

        if (y_valid && !hs) begin
            sel = owner_q;
        end else if (keep) begin
            sel = owner_q;
        end

        if (hs && !keep) begin
            ptr_d = owner_q + 3'd1;
        end

        load = (!y_valid || hs) && (keep || pick.found);

        if (load) begin
            y_d     = mux_out;
            owner_d = sel;
            grant_d = onehot8(sel);
            state_d = HOLD;
        end else if (hs) begin
            grant_d = '0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            grant_q <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            y_q     <= y_d;
        end
    end

    mux_81_16bit_gatelevel #(
        .WIDTH(WIDTH)
    ) u_mux (
        .a (bus.a),
        .b (bus.b),
        .c (bus.c),
        .d (bus.d),
        .e (bus.e),
        .f (bus.f),
        .g (bus.g),
        .h (bus.h),
        .s2(sel[2]),
        .s1(sel[1]),
        .s0(sel[0]),
        .y (mux_out)
    );

    assign bus.y       = y_q;
    assign bus.y_valid = y_valid;
    assign bus.grant   = grant_q;
    assign bus.ack     = grant_q & {N_REQ{hs}};
    assign bus.s2      = sel[2];
    assign bus.s1      = sel[1];
    assign bus.s0      = sel[0];

endmodule

// File: tb/tb_mux_81_rr_arbiter.sv
// Self-checking bench for mux_81_rr_arbiter: directed tables, corner sequences and random traffic.
module tb_mux_81_rr_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mux_81_rr_arbiter_if #(.WIDTH(16)) bus ();

    mux_81_rr_arbiter #(
        .WIDTH    (16),
        .BURST_LEN(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [15:0] d [8];
    assign bus.a = d[0];
    assign bus.b = d[1];
    assign bus.c = d[2];
    assign bus.d = d[3];
    assign bus.e = d[4];
    assign bus.f = d[5];
    assign bus.g = d[6];
    assign bus.h = d[7];

`ifdef MUX81_ARB_BURST_EN
    localparam int BL = 4;
`else
    localparam int BL = 1;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: who holds the output word, where the scan starts, words sent this grant.
    bit          m_valid;
    int          m_owner;
    int          m_ptr;
    int          m_cnt;
    logic [15:0] m_y;

    typedef struct {
        logic [7:0]  req;
        bit          ready;
        logic [7:0]  exp_grant;
        logic [15:0] exp_y;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_cnt   = 0;
        m_y     = 16'h0000;
    endtask

    task automatic decide(input logic [7:0] r, input bit rdy,
                          output bit ld, output bit kp, output int idx);
        int base;
        ld  = 1'b0;
        kp  = 1'b0;
        idx = m_owner;
        if (m_valid && !rdy) return;
        if (m_valid && r[m_owner] && m_cnt < BL) begin
            kp = 1'b1;
            ld = 1'b1;
            return;
        end
        base = m_valid ? (m_owner + 1) % 8 : m_ptr;
        idx  = -1;
        for (int k = 0; k < 8; k++) begin
            if (idx < 0 && r[(base + k) % 8]) idx = (base + k) % 8;
        end
        ld = (idx >= 0);
    endtask

    task automatic cycle(input logic [7:0] r, input bit rdy, input string tag);
        bit ld, kp, hs;
        int idx;
        logic [31:0] exp_ack;
        bus.req     = r;
        bus.y_ready = rdy;
        #1;
        decide(r, rdy, ld, kp, idx);
        hs      = m_valid && rdy;
        exp_ack = hs ? (32'd1 << m_owner) : 32'd0;
        check({tag, ".ack"}, 32'(bus.ack), exp_ack);
        if (ld || (m_valid && !rdy))
            check({tag, ".sel"}, 32'({bus.s2, bus.s1, bus.s0}), 32'(idx));
        @(posedge clk);
        if (hs && !kp) m_ptr = (m_owner + 1) % 8;
        if (ld) begin
            m_y     = d[idx];
            m_cnt   = kp ? m_cnt + 1 : 1;
            m_owner = idx;
            m_valid = 1'b1;
        end else if (hs) begin
            m_valid = 1'b0;
        end
        #1;
        check({tag, ".y_valid"}, 32'(bus.y_valid), 32'(m_valid));
        check({tag, ".grant"}, 32'(bus.grant), m_valid ? (32'd1 << m_owner) : 32'd0);
        check({tag, ".y"}, 32'(bus.y), 32'(m_y));
    endtask

    task automatic reset_dut();
        bus.req     = 8'h00;
        bus.y_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.req     = 8'h00;
        bus.y_ready = 1'b0;
        for (int i = 0; i < 8; i++) d[i] = 16'hA000 | 16'(i);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("reset.y", 32'(bus.y), 32'h0);
        check("reset.y_valid", 32'(bus.y_valid), 32'h0);
        check("reset.grant", 32'(bus.grant), 32'h0);
        check("reset.sel", 32'({bus.s2, bus.s1, bus.s0}), 32'h0);

        // Single requester e, consumer stalled for a while, then drained.
        d[4] = 16'hBEEF;
        cycle(8'h10, 1'b0, "single_load");
        check("single.y", 32'(bus.y), 32'hBEEF);
        check("single.grant", 32'(bus.grant), 32'h10);
        check("single.sel", 32'({bus.s2, bus.s1, bus.s0}), 32'd4);
        for (int i = 0; i < 5; i++) begin
            cycle(8'h10, 1'b0, "single_hold");
            check("single_hold.y", 32'(bus.y), 32'hBEEF);
        end
        bus.req     = 8'h00;
        bus.y_ready = 1'b1;
        #1;
        check("single.ack", 32'(bus.ack), 32'h10);
        cycle(8'h00, 1'b1, "single_ack");
        check("single.idle_valid", 32'(bus.y_valid), 32'h0);
        check("single.idle_grant", 32'(bus.grant), 32'h0);

        // Stall: c and req wiggle while the consumer is not ready.
        d[2] = 16'h5555;
        cycle(8'h04, 1'b0, "stall_load");
        for (int i = 0; i < 4; i++) begin
            d[2] = 16'($urandom);
            cycle(8'($urandom), 1'b0, "stall");
            check("stall.y", 32'(bus.y), 32'h5555);
            check("stall.grant", 32'(bus.grant), 32'h04);
        end
        cycle(8'h00, 1'b1, "stall_release");

        // Wrap: a g transfer leaves the pointer at 7, so h wins before a.
        cycle(8'h40, 1'b0, "wrap_g");
        cycle(8'h81, 1'b1, "wrap_h");
        check("wrap.grant_h", 32'(bus.grant), 32'h80);
        cycle(8'h01, 1'b1, "wrap_a");
        check("wrap.grant_a", 32'(bus.grant), 32'h01);
        cycle(8'h00, 1'b1, "wrap_end");

        // Asynchronous reset in the middle of HOLD.
        d[0] = 16'h1234;
        cycle(8'h01, 1'b0, "rst_load");
        check("rst_load.y", 32'(bus.y), 32'h1234);
        #2;
        bus.y_ready = 1'b1;
        rst_n       = 1'b0;
        #1;
        check("async_rst.y", 32'(bus.y), 32'h0);
        check("async_rst.y_valid", 32'(bus.y_valid), 32'h0);
        check("async_rst.grant", 32'(bus.grant), 32'h0);
        check("async_rst.sel", 32'({bus.s2, bus.s1, bus.s0}), 32'h0);
        check("async_rst.ack", 32'(bus.ack), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Table: fairness with all requesters, then a/b alternation (bursts when enabled).
        for (int i = 0; i < 8; i++) d[i] = 16'hA000 | 16'(i);
        for (int k = 0; k < 9; k++)
            tbl.push_back('{8'hFF, 1'b1, 8'(1 << ((k / BL) % 8)), 16'hA000 | 16'((k / BL) % 8)});
        for (int k = 0; k < 12; k++)
            tbl.push_back('{8'h03, 1'b1, 8'(1 << ((k / BL) % 2)), 16'hA000 | 16'((k / BL) % 2)});
        reset_dut();
        for (int k = 0; k < tbl.size(); k++) begin
            if (k == 9) reset_dut();
            cycle(tbl[k].req, tbl[k].ready, "table");
            check($sformatf("table[%0d].grant", k), 32'(bus.grant), 32'(tbl[k].exp_grant));
            check($sformatf("table[%0d].y", k), 32'(bus.y), 32'(tbl[k].exp_y));
        end

        // Random traffic against the model.
        reset_dut();
        for (int n = 0; n < 400; n++) begin
            logic [7:0] r;
            int mode;
            for (int i = 0; i < 8; i++) d[i] = 16'($urandom);
            mode = $urandom_range(0, 3);
            if (mode == 0)      r = 8'hFF;
            else if (mode == 1) r = 8'(1 << $urandom_range(0, 7));
            else                r = 8'($urandom);
            cycle(r, $urandom_range(0, 3) != 0, "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
